// File: rtl/seq_shift_add_mult_if.sv
// Handshake bundle for seq_shift_add_mult: start/a/b from the requester,
// busy/done/product back from the multiplier.
interface seq_shift_add_mult_if #(
  parameter int WIDTH = 4
);
  logic                   start;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_shift_add_mult.sv
// seq_shift_add_mult: sequential unsigned shift-add multiplier.
// One WIDTH+1-bit add per clock into the upper half of a 2*WIDTH-bit
// accumulator, which then shifts right together with the multiplier.
// Optional feature macro: MULT_EARLY_EXIT_EN -- finish as soon as the
// remaining multiplier bits are all zero, realigning the partial product.
module seq_shift_add_mult #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  seq_shift_add_mult_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [WIDTH-1:0]   mcand_r, mcand_s;
  logic [WIDTH-1:0]   mplier_r, mplier_s;
  logic [2*WIDTH-1:0] acc_r, acc_s;
  logic [2*WIDTH-1:0] product_r, product_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic               done_r, done_s;

  logic [WIDTH-1:0]   addend_s;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] acc_step_s;
  logic [2*WIDTH-1:0] product_fin_s;
  logic [WIDTH-1:0]   mplier_step_s;
  logic [CW-1:0]      cnt_step_s;
  logic               last_step_s;

  // One shift-add step: conditional add into the upper half, carry kept, then shift right
  always_comb begin
    if (mplier_r[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = {WIDTH{1'b0}};
    end
    sum_s         = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, addend_s};
    acc_step_s    = {sum_s, acc_r[WIDTH-1:1]};
    mplier_step_s = {1'b0, mplier_r[WIDTH-1:1]};
    cnt_step_s    = cnt_r + {{(CW-1){1'b0}}, 1'b1};
`ifdef MULT_EARLY_EXIT_EN
    // After k steps the accumulator holds the product scaled up by 2^(WIDTH-k)
    last_step_s   = (cnt_step_s == CW'(WIDTH)) || (mplier_step_s == {WIDTH{1'b0}});
    product_fin_s = acc_step_s >> (CW'(WIDTH) - cnt_step_s);
`else
    last_step_s   = (cnt_step_s == CW'(WIDTH));
    product_fin_s = acc_step_s;
`endif
  end

  // Next-state and next-register values for the IDLE/RUN controller
  always_comb begin
    state_s   = state_r;
    mcand_s   = mcand_r;
    mplier_s  = mplier_r;
    acc_s     = acc_r;
    cnt_s     = cnt_r;
    product_s = product_r;
    done_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s  = ST_RUN;
          mcand_s  = bus.a;
          mplier_s = bus.b;
          acc_s    = {(2*WIDTH){1'b0}};
          cnt_s    = {CW{1'b0}};
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_RUN: begin
        mplier_s = mplier_step_s;
        acc_s    = acc_step_s;
        cnt_s    = cnt_step_s;
        if (last_step_s) begin
          state_s   = ST_IDLE;
          product_s = product_fin_s;
          done_s    = 1'b1;
        end else begin
          state_s   = ST_RUN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; synchronous reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      mcand_r   <= {WIDTH{1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      cnt_r     <= {CW{1'b0}};
      product_r <= {(2*WIDTH){1'b0}};
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      mcand_r   <= mcand_s;
      mplier_r  <= mplier_s;
      acc_r     <= acc_s;
      cnt_r     <= cnt_s;
      product_r <= product_s;
      done_r    <= done_s;
    end
  end

  assign bus.busy    = (state_r == ST_RUN);
  assign bus.done    = done_r;
  assign bus.product = product_r;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed bench for seq_shift_add_mult at WIDTH 2, 4 and 8.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_seq_shift_add_mult;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   dc2 = 0;
  int   dc4 = 0;
  int   dc8 = 0;

  seq_shift_add_mult_if #(.WIDTH(2)) if2 ();
  seq_shift_add_mult_if #(.WIDTH(4)) if4 ();
  seq_shift_add_mult_if #(.WIDTH(8)) if8 ();

  seq_shift_add_mult #(.WIDTH(2)) u_w2 (.clk(clk), .rst(rst), .bus(if2));
  seq_shift_add_mult #(.WIDTH(4)) u_w4 (.clk(clk), .rst(rst), .bus(if4));
  seq_shift_add_mult #(.WIDTH(8)) u_w8 (.clk(clk), .rst(rst), .bus(if8));

  always #5 clk = ~clk;

  // Count done pulses per instance
  always @(posedge clk) begin
    if (if2.done === 1'b1) dc2++;
    if (if4.done === 1'b1) dc4++;
    if (if8.done === 1'b1) dc8++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int sel, input logic st, input logic [15:0] aa, input logic [15:0] bb);
    case (sel)
      2: begin if2.start = st; if2.a = aa[1:0]; if2.b = bb[1:0]; end
      4: begin if4.start = st; if4.a = aa[3:0]; if4.b = bb[3:0]; end
      default: begin if8.start = st; if8.a = aa[7:0]; if8.b = bb[7:0]; end
    endcase
  endtask

  // {busy, done, product zero-extended to 16 bits}
  function automatic logic [17:0] read_bus(input int sel);
    case (sel)
      2: return {if2.busy, if2.done, 12'd0, if2.product};
      4: return {if4.busy, if4.done, 8'd0, if4.product};
      default: return {if8.busy, if8.done, if8.product};
    endcase
  endfunction

  // Expected cycles from accepting edge to done
  function automatic int exp_lat(input int w, input logic [15:0] bb);
    int hb;
    hb = 1;
    for (int i = 0; i < w; i++) if (bb[i]) hb = i + 1;
`ifdef MULT_EARLY_EXIT_EN
    return hb;
`else
    return (hb > w) ? hb : w;
`endif
  endfunction

  // Start one op in the current cycle, optionally pulse start (1*1) at cycle inj, stop at the done cycle
  task automatic run_op(input int sel, input logic [15:0] aa, input logic [15:0] bb,
                        input int exp_p, input int inj, input string tag);
    int n;
    int bc;
    logic [17:0] o;
    set_in(sel, 1'b1, aa, bb);
    @(negedge clk);
    n  = 0;
    bc = 0;
    o  = read_bus(sel);
    while (o[16] !== 1'b1 && n < 40) begin
      if (o[17] === 1'b1) bc++;
      if (n == inj) set_in(sel, 1'b1, 16'd1, 16'd1);
      else          set_in(sel, 1'b0, 16'd0, 16'd0);
      @(negedge clk);
      n++;
      o = read_bus(sel);
    end
    set_in(sel, 1'b0, 16'd0, 16'd0);
    check_val({tag, " latency"}, n, exp_lat(sel, bb));
    check_val({tag, " product"}, {16'd0, o[15:0]}, exp_p);
    check_val({tag, " busy at done"}, {31'd0, o[17]}, 32'd0);
    check_val({tag, " busy cycles"}, bc, n);
  endtask

  // One cycle later: done has dropped and product is held
  task automatic idle_check(input int sel, input int exp_p, input string tag);
    logic [17:0] o;
    @(negedge clk);
    o = read_bus(sel);
    check_val({tag, " done falls"}, {31'd0, o[16]}, 32'd0);
    check_val({tag, " product held"}, {16'd0, o[15:0]}, exp_p);
  endtask

  int prod_tbl [16] = '{0, 0, 0, 0, 0, 1, 2, 3, 0, 2, 4, 6, 0, 3, 6, 9};

  initial begin
    logic [17:0] o;
    rst = 1'b1;
    set_in(2, 1'b0, 16'd0, 16'd0);
    set_in(4, 1'b0, 16'd0, 16'd0);
    set_in(8, 1'b0, 16'd0, 16'd0);
    repeat (3) @(negedge clk);
    o = read_bus(8);
    check_val("reset w8 state", {14'd0, o}, 32'd0);
    o = read_bus(4);
    check_val("reset w4 state", {14'd0, o}, 32'd0);
    o = read_bus(2);
    check_val("reset w2 state", {14'd0, o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // WIDTH=2 full table
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        run_op(2, 16'(i), 16'(j), prod_tbl[i*4+j], -1, $sformatf("w2 %0dx%0d", i, j));
        idle_check(2, prod_tbl[i*4+j], "w2");
      end
    end
    check_val("w2 done count", dc2, 16);

    // WIDTH=4 back-to-back: second start held during the done cycle
    run_op(4, 16'd15, 16'd15, 225, -1, "b2b 15x15");
    run_op(4, 16'd7, 16'd3, 21, -1, "b2b 7x3");
    idle_check(4, 21, "b2b");
    check_val("w4 done count", dc4, 2);

    // WIDTH=8 extremes and ignored mid-flight start
    run_op(8, 16'd255, 16'd255, 65025, -1, "w8 255x255");
    idle_check(8, 65025, "w8 max");
    run_op(8, 16'd13, 16'd11, 143, 2, "w8 13x11 ign");
    idle_check(8, 143, "w8 ign");
    repeat (10) @(negedge clk);
    check_val("w8 no extra done", dc8, 2);
    o = read_bus(8);
    check_val("w8 idle after ign", {14'd0, o}, 32'd143);

    // Reset mid-operation
    set_in(8, 1'b1, 16'd200, 16'd100);
    @(negedge clk);
    set_in(8, 1'b0, 16'd0, 16'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    o = read_bus(8);
    check_val("rst mid busy", {31'd0, o[17]}, 32'd0);
    check_val("rst mid done", {31'd0, o[16]}, 32'd0);
    check_val("rst mid product", {16'd0, o[15:0]}, 32'd0);
    repeat (12) @(negedge clk);
    check_val("rst mid no done", dc8, 2);
    run_op(8, 16'd5, 16'd6, 30, -1, "w8 5x6");
    idle_check(8, 30, "w8 5x6");

    // Small multipliers (early-exit latency when enabled)
    run_op(8, 16'd9, 16'd1, 9, -1, "w8 9x1");
    idle_check(8, 9, "w8 9x1");
    run_op(8, 16'd9, 16'd0, 0, -1, "w8 9x0");
    idle_check(8, 0, "w8 9x0");
    run_op(8, 16'd3, 16'd128, 384, -1, "w8 3x128");
    idle_check(8, 384, "w8 3x128");
    check_val("w8 done count", dc8, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
